// File: rtl/mem_arb_pkg.sv
// Shared types and funct3 encodings for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Access width in bytes; undefined encodings fall back to 1 and are rejected elsewhere.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check of one memory request: encoding, alignment and range.
module mem_access_check
  import mem_arb_pkg::*;
#(
  parameter int MEMSIZE = 64
) (
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic        we,
  output logic        legal
);

  logic [32:0] last_byte;
  logic        bad_f3, bad_store, bad_half, bad_word, bad_range;

  always_comb begin
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    last_byte = {1'b0, addr} + 33'(access_size(funct3)) - 33'd1;
    bad_f3    = funct3 inside {3'd3, 3'd6, 3'd7};
    bad_store = we && (funct3 inside {F3_BU, F3_HU});
    bad_half  = (funct3 == F3_H || funct3 == F3_HU) && addr[0];
    bad_word  = (funct3 == F3_W) && (addr[1:0] != 2'b00);
    bad_range = last_byte >= 33'(MEMSIZE);
    legal     = !(bad_f3 || bad_store || bad_half || bad_word || bad_range);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one registered memory port,
// one access per grant with a single response cycle each.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEMSIZE    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_value,
  output logic [2:0]  mem_funct3,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_t        state_reg, state_next;
  owner_t        owner_reg;
  logic [CW-1:0] starve_reg;
  logic          we_reg, legal_reg, err_reg;
  logic [31:0]   rdata_reg;

  logic          arb_en, pick_if, win_we, win_legal;
  logic [31:0]   win_addr, win_wdata;
  logic [2:0]    win_f3;

  always_comb begin
    arb_en    = (state_reg == IDLE || state_reg == RESP) && (if_req || d_req);
    // Data is the older pipeline stage, but fetch is forced once it has waited long enough
    pick_if   = if_req && (!d_req || starve_reg == CW'(STARVE_MAX));
    win_addr  = pick_if ? if_addr : d_addr;
    win_wdata = pick_if ? 32'd0   : d_wdata;
    win_f3    = pick_if ? F3_W    : d_funct3;
    win_we    = pick_if ? 1'b0    : d_we;
  end

  mem_access_check #(.MEMSIZE(MEMSIZE)) u_check (
    .addr   (win_addr),
    .funct3 (win_f3),
    .we     (win_we),
    .legal  (win_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_en) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = arb_en ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg  <= OWN_IF;
      mem_addr   <= '0;
      mem_value  <= '0;
      mem_funct3 <= '0;
      we_reg     <= 1'b0;
      legal_reg  <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (arb_en) begin
        owner_reg  <= pick_if ? OWN_IF : OWN_D;
        mem_addr   <= win_addr;
        mem_value  <= win_wdata;
        mem_funct3 <= win_f3;
        we_reg     <= win_we;
        legal_reg  <= win_legal;
        if_gnt     <= pick_if;
        d_gnt      <= !pick_if;
        // Strobes are registered so memory sees them only during the ACCESS cycle
        mem_read   <= win_legal && !win_we;
        mem_write  <= win_legal && win_we;
      end
      if (state_reg == ACCESS) begin
        rdata_reg <= (legal_reg && !we_reg) ? mem_data : 32'd0;
        err_reg   <= !legal_reg;
        if_rvalid <= (owner_reg == OWN_IF);
        d_rvalid  <= (owner_reg == OWN_D);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_reg <= '0;
    else if (!if_req || (arb_en && pick_if))
      starve_reg <= '0;
    else if (arb_en && starve_reg != CW'(STARVE_MAX))
      starve_reg <= starve_reg + CW'(1);
  end

  // Response data is shared; each side qualifies it with its own rvalid
  assign if_rdata = rdata_reg;
  assign d_rdata  = rdata_reg;
  assign if_err   = err_reg;
  assign d_err    = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grant monitor predicts responses from a byte-array
// reference memory, response monitor checks data, fault flag and latency.
module tb_mem_arbiter;

  localparam int MEMSIZE    = 64;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [2:0]  d_funct3 = '0;
  logic [31:0] mem_addr, mem_value, mem_data;
  logic [2:0]  mem_funct3;
  logic        mem_read, mem_write;

  mem_arbiter #(.MEMSIZE(MEMSIZE), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_value(mem_value), .mem_funct3(mem_funct3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int checks = 0, fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- memory device attached to the port ----------------
  logic [7:0]  env_mem [MEMSIZE];
  logic [7:0]  ref_mem [MEMSIZE];
  logic [5:0]  ea;
  logic [31:0] raw;

  always_comb begin
    ea  = mem_addr[5:0];
    raw = {env_mem[ea + 6'd3], env_mem[ea + 6'd2], env_mem[ea + 6'd1], env_mem[ea]};
    case (mem_funct3)
      3'd0:    mem_data = {{24{raw[7]}}, raw[7:0]};
      3'd1:    mem_data = {{16{raw[15]}}, raw[15:0]};
      3'd4:    mem_data = {24'd0, raw[7:0]};
      3'd5:    mem_data = {16'd0, raw[15:0]};
      default: mem_data = raw;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[mem_addr[5:0]] <= mem_value[7:0];
      if (mem_funct3 != 3'd0) env_mem[mem_addr[5:0] + 6'd1] <= mem_value[15:8];
      if (mem_funct3 == 3'd2) begin
        env_mem[mem_addr[5:0] + 6'd2] <= mem_value[23:16];
        env_mem[mem_addr[5:0] + 6'd3] <= mem_value[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rd, output logic ok);
    int size;
    longint v;
    size = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2 ? 4 : 1);
    ok = !(f3 == 3'd3 || f3 >= 3'd6) && !(we && f3 >= 3'd4) && (addr % size == 0) &&
         (longint'({32'd0, addr}) + size <= MEMSIZE);
    rd = 32'd0;
    if (ok && we) begin
      for (int k = 0; k < size; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
    end else if (ok) begin
      v = 0;
      for (int k = 0; k < size; k++) v += longint'(ref_mem[int'(addr) + k]) << (8 * k);
      if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v -= longint'(1) << (8 * size);
      rd = v[31:0];
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t  if_q[$], d_q[$];
  string grant_log = "";
  int    gnt_cyc[$];
  bit    mon_en = 1'b1;
  int    rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_if = '0, last_d = '0;

  always @(negedge clk) begin
    rd_cnt += int'(mem_read);
    wr_cnt += int'(mem_write);
  end

  // Grant monitor: predicts the response and checks the strobes of the access cycle
  always @(negedge clk) begin : gmon
    exp_t        e;
    logic        ok, isif, we;
    logic [31:0] rd, a;
    if (rst_n && mon_en) begin
      if (!if_gnt && !d_gnt) chk("strobe_outside_access", {30'd0, mem_read, mem_write}, 32'd0);
      else begin
        chk("gnt_exclusive", {31'd0, if_gnt && d_gnt}, 32'd0);
        isif = if_gnt;
        chk("gnt_has_req", {31'd0, isif ? if_req : d_req}, 32'd1);
        we = isif ? 1'b0 : d_we;
        a  = isif ? if_addr : d_addr;
        if (isif) model(1'b0, if_addr, 32'd0, 3'd2, rd, ok);
        else      model(d_we, d_addr, d_wdata, d_funct3, rd, ok);
        chk("mem_read", {31'd0, mem_read}, {31'd0, ok && !we});
        chk("mem_write", {31'd0, mem_write}, {31'd0, ok && we});
        if (ok) begin
          chk("mem_addr", mem_addr, a);
          chk("mem_funct3", {29'd0, mem_funct3}, {29'd0, isif ? 3'd2 : d_funct3});
          if (we) chk("mem_value", mem_value, d_wdata);
        end
        e.rdata = rd; e.err = !ok; e.cyc = cycle + 1;
        if (isif) if_q.push_back(e); else d_q.push_back(e);
        grant_log = {grant_log, isif ? "I" : "D"};
        gnt_cyc.push_back(cycle);
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin : rmon
    exp_t e;
    if (rst_n && mon_en) begin
      if (if_rvalid && d_rvalid) chk("rvalid_exclusive", 32'd1, 32'd0);
      if (d_rvalid) begin
        if (d_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = d_q.pop_front();
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_err", {31'd0, d_err}, {31'd0, e.err});
          chk("d_latency_cycle", 32'(cycle), 32'(e.cyc));
          last_d = d_rdata;
        end
      end
      if (if_rvalid) begin
        if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_err", {31'd0, if_err}, {31'd0, e.err});
          chk("if_latency_cycle", 32'(cycle), 32'(e.cyc));
          last_if = if_rdata;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic any_out();
    return |{if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
             mem_addr, mem_value, mem_funct3, mem_read, mem_write};
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < MEMSIZE; i++) if (env_mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic wait_gnt(input bit isif, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (isif ? if_gnt : d_gnt) begin got = 1'b1; break; end
    end
    if (!got) chk(isif ? "if_gnt_timeout" : "d_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic d_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input bit hold);
    bit got;
    d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3; d_req = 1'b1;
    wait_gnt(1'b0, got);
    @(posedge clk); #1;
    if (!hold) d_req = 1'b0;
  endtask

  task automatic if_issue(input logic [31:0] addr);
    bit got;
    if_addr = addr; if_req = 1'b1;
    wait_gnt(1'b1, got);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (if_q.size() == 0 && d_q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (if_q.size() != 0 || d_q.size() != 0) begin
      chk("response_timeout", 32'(if_q.size() + d_q.size()), 32'd0);
      if_q.delete(); d_q.delete();
    end
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 100; i++) begin
      if (grant_log.len() >= n) break;
      @(negedge clk); #1;
    end
    if (grant_log.len() < n) chk("grant_count_timeout", 32'(grant_log.len()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0;
    bit got;
    for (int i = 0; i < MEMSIZE; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    env_mem[8] = 8'h44; env_mem[9] = 8'h33; env_mem[10] = 8'h22; env_mem[11] = 8'h11;
    for (int i = 8; i < 12; i++) ref_mem[i] = env_mem[i];

    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", {31'd0, any_out()}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch only
    r0 = rd_cnt;
    if_issue(32'h8);
    drain();
    chk("fetch_word", last_if, 32'h11223344);
    chk("fetch_read_cycles", 32'(rd_cnt - r0), 32'd1);

    // Store half then signed / unsigned half loads
    w0 = wr_cnt;
    d_issue(1'b1, 32'h10, 32'hABCD8001, 3'd1, 1'b0);
    drain();
    chk("store_write_cycles", 32'(wr_cnt - w0), 32'd1);
    chk("store_rdata_zero", last_d, 32'd0);
    d_issue(1'b0, 32'h10, 32'h0, 3'd1, 1'b0);
    drain();
    chk("lh_sign_ext", last_d, 32'hFFFF8001);
    d_issue(1'b0, 32'h10, 32'h0, 3'd5, 1'b0);
    drain();
    chk("lhu_zero_ext", last_d, 32'h00008001);

    // Faults: none may strobe memory
    r0 = rd_cnt; w0 = wr_cnt;
    d_issue(1'b0, 32'h6,  32'h0,        3'd2, 1'b0);
    d_issue(1'b1, 32'h3,  32'h12345678, 3'd1, 1'b0);
    d_issue(1'b0, 32'h3E, 32'h0,        3'd2, 1'b0);
    d_issue(1'b0, 32'h4,  32'h0,        3'd3, 1'b0);
    d_issue(1'b1, 32'h4,  32'h5555AAAA, 3'd4, 1'b0);
    d_issue(1'b0, 32'h40, 32'h0,        3'd0, 1'b0);
    d_issue(1'b1, 32'hFFFFFFFE, 32'h1,  3'd1, 1'b0);
    if_issue(32'h3E);
    drain();
    chk("fault_read_cycles", 32'(rd_cnt - r0), 32'd0);
    chk("fault_write_cycles", 32'(wr_cnt - w0), 32'd0);
    chk("fault_mem_unchanged", 32'(mem_diff()), 32'd0);
    r0 = rd_cnt;
    d_issue(1'b0, 32'h3C, 32'h0, 3'd2, 1'b0);
    drain();
    chk("last_word_legal_read", 32'(rd_cnt - r0), 32'd1);

    // Contention with both requests held
    d_we = 1'b0; d_addr = 32'h0; d_funct3 = 3'd2; if_addr = 32'h4;
    grant_log = "";
    d_req = 1'b1; if_req = 1'b1;
    wait_log(10);
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0;
    drain();
    chk_str("starve_order", grant_log, "DDDDIDDDDI");

    // Counter clears while fetch is not requesting
    grant_log = "";
    d_req = 1'b1; if_req = 1'b1;
    wait_log(3);
    @(posedge clk); #1;
    if_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    wait_log(grant_log.len() + 1);
    @(posedge clk); #1;
    grant_log = "";
    if_req = 1'b1;
    wait_log(5);
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0;
    drain();
    chk_str("starve_clear_order", grant_log, "DDDDI");

    // Back-to-back data requests
    gnt_cyc.delete();
    d_issue(1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 1'b1);
    d_issue(1'b0, 32'h20, 32'h0,        3'd2, 1'b1);
    d_issue(1'b0, 32'h22, 32'h0,        3'd0, 1'b1);
    d_issue(1'b0, 32'h20, 32'h0,        3'd4, 1'b0);
    drain();
    chk("b2b_last_lbu", last_d, 32'h0000000D);
    if (gnt_cyc.size() == 4)
      for (int i = 1; i < 4; i++) chk("b2b_gnt_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd2);
    else
      chk("b2b_gnt_count", 32'(gnt_cyc.size()), 32'd4);

    // Randomized traffic from both requesters
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          d_issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, MEMSIZE + 7)),
                  $urandom, 3'($urandom_range(0, 7)), 1'b0);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          if_issue(32'($urandom_range(0, 17) * 4 + ($urandom_range(0, 7) == 0 ? 2 : 0)));
        end
      end
    join
    drain();
    chk("random_mem_contents", 32'(mem_diff()), 32'd0);

    // Reset in the middle of a store access
    mon_en = 1'b0;
    d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'hDEADBEEF; d_funct3 = 3'd2; d_req = 1'b1;
    wait_gnt(1'b0, got);
    chk("reset_store_strobe", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_write_drop", {31'd0, mem_write}, 32'd0);
    chk("reset_async_outputs", {31'd0, any_out()}, 32'd0);
    d_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_held_outputs", {31'd0, any_out()}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_rvalid_after_reset", {31'd0, d_rvalid | if_rvalid}, 32'd0);
    end
    chk("reset_mem_unchanged", 32'(mem_diff()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-addressed data memory port between the instruction-fetch requester and the load/store (data) requester of the pipelined core. Requests are captured into registers, so every memory control and data input is driven from flops and held stable for exactly one access cycle. Each request gets one read-data/error response. Misaligned, out-of-range and illegal-funct3 accesses are rejected without touching memory.

Parameters:
MEMSIZE, 64, memory size in bytes; the last legal byte is MEMSIZE-1.
STARVE_MAX, 4, maximum consecutive data grants while if_req is pending before fetch is forced.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  32  fetch byte address; always a word read
if_gnt  out  1  fetch request accepted (one-cycle pulse)
if_rvalid  out  1  fetch response valid (one-cycle pulse)
if_rdata  out  32  fetch read data
if_err  out  1  fetch fault; qualified by if_rvalid
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_funct3  in  3  RV32 load/store funct3
d_gnt  out  1  data request accepted (one-cycle pulse)
d_rvalid  out  1  data response valid (one-cycle pulse)
d_rdata  out  32  load data; 0 for stores
d_err  out  1  data fault; qualified by d_rvalid
mem_addr  out  32  to memory addr
mem_value  out  32  to memory value
mem_funct3  out  3  to memory funct3
mem_read  out  1  to memory read
mem_write  out  1  to memory write
mem_data  in  32  from memory data (combinational read)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; starvation counter 0.
- Reset mid-ACCESS: mem_write/mem_read drop immediately (asynchronously). The in-flight request produces no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, or RESP, with any req sampled high at a rising edge:
  - Arbitrate and latch the winner's addr, wdata, funct3 and we. Fetch is latched as funct3=2, we=0.
  - Latch the legality result.
  - Next state is ACCESS, with the winner's gnt high for that cycle only.
- No req sampled: RESP goes to IDLE; IDLE stays in IDLE.
- ACCESS:
  - mem_addr, mem_value and mem_funct3 come from the latched registers.
  - If the access is legal, mem_read = !we and mem_write = we for exactly this cycle; otherwise both are 0.
  - On the closing edge: rdata register <= (legal && !we) ? mem_data : 0; err register <= !legal. Next state is RESP.
- RESP: the owner's rvalid is high for one cycle, with rdata and err stable. The other requester's rvalid stays 0.
- Timing: the request is sampled at edge N; gnt is high in cycle N..N+1; rvalid is high in cycle N+1..N+2. Peak throughput is one access per 2 cycles (back-to-back via RESP to ACCESS).
- Requester contract: keep req and all fields stable until gnt is seen. Deassert req, or present the next request, at the edge that ends the gnt cycle.
- Arbitration priority: data wins when both requests are present (older pipeline stage), except when the starvation counter equals STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments on each data grant while if_req is high.
  - Clears on a fetch grant, or on any edge where if_req is low.
  - Saturates at STARVE_MAX.
- Legality, for a single requester: illegal if any of the following holds:
  - funct3 is in {3,6,7};
  - a store has funct3 in {4,5};
  - funct3 is in {1,5} and addr[0] != 0;
  - funct3 == 2 and addr[1:0] != 0;
  - addr + size - 1 >= MEMSIZE, with size 1/2/4. Compute this without 32-bit wrap using a 33-bit sum.
- Illegal access: no memory strobe, rdata = 0, err = 1.
- Outside ACCESS, mem_read and mem_write are 0. mem_addr, mem_value and mem_funct3 hold their last latched value.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {OWN_IF, OWN_D};
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
- One sub-module, mem_access_check: combinational (addr, funct3, we) -> legal. It is instantiated once, on the arbitration winner.

Test Plan:
- Fetch only: if_addr=0x8, memory holding 0x11223344 at byte 8 -> if_gnt at cycle 1, if_rvalid at cycle 2 with if_rdata=0x11223344 and if_err=0. mem_read is high for exactly one cycle.
- Store then load: d_we=1, addr=0x10, funct3=1, wdata=0xABCD8001, then load funct3=1 at 0x10 -> d_rdata=0xFFFF8001. A load with funct3=5 returns 0x00008001. mem_write is high for exactly 1 cycle.
- Contention: both req high every cycle, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF. The counter clears when if_req drops.
- Faults: word load at 0x6; half store at 0x3; load at 0x3E with funct3=2; funct3=3; funct3=4 with we=1. Each -> d_err=1, d_rdata=0, mem_read=mem_write=0 throughout, and memory contents unchanged.
- Reset: rst_n low during the ACCESS of a store -> mem_write falls asynchronously, no d_rvalid ever follows, and all outputs read 0 while reset is held.
- Back-to-back: d_req held continuously with new fields at each gnt -> one response every 2 cycles, with gnt and rvalid for consecutive requests on alternating cycles.
